// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage with one-outstanding imem requests, skid buffer and redirect handling
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall, redirect          hazard hold of IF; taken branch/jump from EX
//   redirectPc               redirect target (low two bits ignored)
//   imemReq, imemAddr        single-cycle request strobe and address to the I-cache
//   imemRvalid, imemRdata    response strobe and word from the I-cache
//   instrF, pcF, pcPlus4F    instruction, its PC and PC+4 toward IF/ID
//   validF, bubbleF          real instruction present; flush request for IF/ID
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcPlus4F,
    output logic        validF,
    output logic        bubbleF
);
    logic [31:0] next_pc_q, next_pc_d, req_pc_q, req_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d, buf_pc_q, buf_pc_d, target;
    logic        outstanding_q, outstanding_d, discard_q, discard_d;
    logic        buf_valid_q, buf_valid_d;
    logic        resp_now, live_resp, slot_free, capture, consume;
    always_comb begin
        target        = redirectPc & 32'hFFFF_FFFC;
        resp_now      = outstanding_q & imemRvalid;
        live_resp     = resp_now & !discard_q;
        slot_free     = !outstanding_q | resp_now;
        validF        = !redirect & (buf_valid_q | live_resp);
        instrF        = buf_valid_q ? buf_instr_q : imemRdata;
        pcF           = buf_valid_q ? buf_pc_q : req_pc_q;
        pcPlus4F      = pcF + 32'd4;
        // rst gating keeps the request strobe and flush quiet while reset is held
        bubbleF       = !rst & !validF & !stall;
        // a redirect drops the buffer and any live response, so stall cannot block it
        imemReq       = !rst & slot_free & (redirect | !(stall & (buf_valid_q | live_resp)));
        imemAddr      = redirect ? target : next_pc_q;
        consume       = validF & !stall;
        capture       = live_resp & stall & !buf_valid_q & !redirect;
        next_pc_d     = imemReq ? imemAddr + 32'd4 : (redirect ? target : next_pc_q);
        req_pc_d      = imemReq ? imemAddr : req_pc_q;
        outstanding_d = imemReq | (outstanding_q & !resp_now);
        // a redirect with a response still pending marks that response stale
        discard_d     = !resp_now & (discard_q | (redirect & outstanding_q));
        buf_valid_d   = redirect ? 1'b0 : capture ? 1'b1 : consume ? 1'b0 : buf_valid_q;
        buf_instr_d   = capture ? imemRdata : buf_instr_q;
        buf_pc_d      = capture ? req_pc_q : buf_pc_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc_q     <= RESET_PC;
            req_pc_q      <= 32'h0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_instr_q   <= 32'h0;
            buf_pc_q      <= 32'h0;
        end else begin
            next_pc_q     <= next_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            buf_valid_q   <= buf_valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc_q      <= buf_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a variable-latency instruction cache
module tb_fetch_unit;
    logic        clk = 1'b0, rst, stall, redirect, imemReq, imemRvalid, validF, bubbleF;
    logic [31:0] redirectPc, imemAddr, imemRdata, instrF, pcF, pcPlus4F;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'h0;
    int          cnt = 0, lat = 1, total = 0, bad = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemRvalid(imemRvalid), .imemRdata(imemRdata),
        .instrF(instrF), .pcF(pcF), .pcPlus4F(pcPlus4F), .validF(validF), .bubbleF(bubbleF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // cache: one response per request, lat cycles later; not reset by rst
    assign imemRvalid = pend && cnt == 1;
    assign imemRdata  = imemRvalid ? word(paddr) : 32'h0;
    always @(posedge clk) begin
        if (imemReq) begin
            pend  <= 1'b1;
            cnt   <= lat;
            paddr <= imemAddr;
        end else if (pend) begin
            cnt <= cnt - 1;
            if (cnt == 1) pend <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".validF"}, {31'b0, validF}, {31'b0, v});
        if (v) begin
            chk({tag, ".pcF"}, pcF, pc);
            chk({tag, ".instrF"}, instrF, word(pc));
            chk({tag, ".pcPlus4F"}, pcPlus4F, pc + 32'd4);
        end
    endtask

    task automatic req_chk(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".imemReq"}, {31'b0, imemReq}, {31'b0, r});
        if (r) chk({tag, ".imemAddr"}, imemAddr, a);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, ".imemReq"}, {31'b0, imemReq}, 32'd0);
        chk({tag, ".validF"}, {31'b0, validF}, 32'd0);
        chk({tag, ".bubbleF"}, {31'b0, bubbleF}, 32'd0);
        chk({tag, ".pcF"}, pcF, 32'h0);
        chk({tag, ".pcPlus4F"}, pcPlus4F, 32'h4);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
        repeat (2) @(posedge clk);
        smp; rst_chk("reset"); chk("reset.instrF", instrF, 32'h0);
        nx; rst = 1'b0;
        smp; req_chk("c0", 1, 32'h0); out_chk("c0", 0, 0);
        nx; smp; out_chk("c1", 1, 32'h0); req_chk("c1", 1, 32'h4);
        chk("c1.instrF_nop", instrF, 32'h0000_0013);
        nx; smp; out_chk("c2", 1, 32'h4); req_chk("c2", 1, 32'h8);
        nx; stall = 1'b1;
        smp; out_chk("stall0", 1, 32'h8); req_chk("stall0", 0, 0);
        nx; smp; out_chk("stall1", 1, 32'h8); req_chk("stall1", 0, 0);
        nx; smp; out_chk("stall2", 1, 32'h8); req_chk("stall2", 0, 0);
        nx; stall = 1'b0;
        smp; out_chk("unstall", 1, 32'h8); req_chk("unstall", 1, 32'hC);
        nx; lat = 5;
        smp; out_chk("c7", 1, 32'hC); req_chk("c7", 1, 32'h10);
        for (int i = 0; i < 4; i++) begin
            nx; smp; out_chk("miss", 0, 0); req_chk("miss", 0, 0);
            chk("miss.bubbleF", {31'b0, bubbleF}, 32'd1);
        end
        nx; lat = 4;
        smp; out_chk("missdone", 1, 32'h10); req_chk("missdone", 1, 32'h14);
        chk("missdone.bubbleF", {31'b0, bubbleF}, 32'd0);
        nx; redirect = 1'b1; redirectPc = 32'h203;
        smp; out_chk("redir", 0, 0); req_chk("redir", 0, 0);
        chk("redir.bubbleF", {31'b0, bubbleF}, 32'd1);
        nx; redirect = 1'b0;
        smp; out_chk("wait0", 0, 0); req_chk("wait0", 0, 0);
        nx; smp; out_chk("wait1", 0, 0); req_chk("wait1", 0, 0);
        nx; lat = 1;
        smp; chk("stale.rvalid", {31'b0, imemRvalid}, 32'd1);
        out_chk("stale", 0, 0); req_chk("stale", 1, 32'h200);
        nx; smp; out_chk("tgt", 1, 32'h200); req_chk("tgt", 1, 32'h204);
        nx; stall = 1'b1; redirect = 1'b1; redirectPc = 32'h300;
        smp; out_chk("redir_live", 0, 0); req_chk("redir_live", 1, 32'h300);
        chk("redir_live.bubbleF", {31'b0, bubbleF}, 32'd0);
        nx; stall = 1'b0; redirect = 1'b0; lat = 5;
        smp; out_chk("tgt2", 1, 32'h300); req_chk("tgt2", 1, 32'h304);
        nx; smp; out_chk("miss2", 0, 0);
        nx; rst = 1'b1;
        #1; rst_chk("midrst");
        nx; lat = 1;
        smp; rst_chk("midrst1");
        nx; smp; rst_chk("midrst2");
        nx; rst = 1'b0;
        smp; chk("rel.stale_rvalid", {31'b0, imemRvalid}, 32'd1);
        out_chk("rel", 0, 0); req_chk("rel", 1, 32'h0);
        nx; smp; out_chk("rel1", 1, 32'h0); req_chk("rel1", 1, 32'h4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
